// File: rtl/ipsxe_floating_point_in_join_v1_0.sv
// Input-side joiner for the floating-point core: buffers up to three AXI4-Stream
// channels in 2-entry FIFOs and presents one joined beat once every enabled channel holds data.

module ipsxe_fp_in_join_fifo #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         ready_o,
    output logic         nonempty_o,
    output logic [W-1:0] head_o
);

    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, rd_ptr_q;
    logic         ready_q;
    logic [W-1:0] mem_q [2];
    logic         push;

    assign push = valid_i & ready_q & ce;

    always_comb begin
        count_d = count_q;
        if (push && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b0;
        end else if (ce) begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            ready_q <= (count_d < 2'd2);
        end
    end

    // NOTE: payload storage has no reset; an empty FIFO never exposes it as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign ready_o    = ready_q;
    assign nonempty_o = (count_q != 2'd0);
    assign head_o     = mem_q[rd_ptr_q];

endmodule

module ipsxe_floating_point_in_join_v1_0 #(
    parameter int HAS_B          = 1,
    parameter int HAS_OP         = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 8,
    parameter int A_TUSER_WIDTH  = 1,
    parameter int B_TUSER_WIDTH  = 1,
    parameter int OP_TUSER_WIDTH = 1,
    localparam int TUSER_IN_ABCOPERATION_WIDTH =
        A_TUSER_WIDTH + HAS_B * B_TUSER_WIDTH + HAS_OP * OP_TUSER_WIDTH
) (
    input  logic                                   i_aclk,
    input  logic                                   i_areset_n,
    input  logic                                   i_aclken,
    input  logic                                   i_axi4s_a_tvalid,
    output logic                                   o_axi4s_a_tready,
    input  logic [DATA_WIDTH-1:0]                  i_axi4s_a_tdata,
    input  logic [A_TUSER_WIDTH-1:0]               i_axi4s_a_tuser,
    input  logic                                   i_axi4s_b_tvalid,
    output logic                                   o_axi4s_b_tready,
    input  logic [DATA_WIDTH-1:0]                  i_axi4s_b_tdata,
    input  logic [B_TUSER_WIDTH-1:0]               i_axi4s_b_tuser,
    input  logic                                   i_axi4s_op_tvalid,
    output logic                                   o_axi4s_op_tready,
    input  logic [OP_WIDTH-1:0]                    i_axi4s_op_tdata,
    input  logic [OP_TUSER_WIDTH-1:0]              i_axi4s_op_tuser,
    output logic                                   o_join_valid,
    input  logic                                   i_join_ready,
    output logic [DATA_WIDTH-1:0]                  o_join_a,
    output logic [DATA_WIDTH-1:0]                  o_join_b,
    output logic [OP_WIDTH-1:0]                    o_join_op,
    output logic [TUSER_IN_ABCOPERATION_WIDTH-1:0] o_join_abcoperation_tuser
);

    localparam int AW = A_TUSER_WIDTH + DATA_WIDTH;
    localparam int BW = B_TUSER_WIDTH + DATA_WIDTH;
    localparam int OW = OP_TUSER_WIDTH + OP_WIDTH;

    logic                      pop;
    logic                      a_ne, b_ne, op_ne;
    logic [AW-1:0]             a_head;
    logic [B_TUSER_WIDTH-1:0]  b_user;
    logic [OP_TUSER_WIDTH-1:0] op_user;

    // Validity comes only from FIFO counts, so no input reaches an output combinationally.
    assign o_join_valid = a_ne & b_ne & op_ne;
    assign pop          = o_join_valid & i_join_ready & i_aclken;

    ipsxe_fp_in_join_fifo #(.W(AW)) u_fifo_a (
        .clk        (i_aclk),
        .rst_n      (i_areset_n),
        .ce         (i_aclken),
        .valid_i    (i_axi4s_a_tvalid),
        .data_i     ({i_axi4s_a_tuser, i_axi4s_a_tdata}),
        .pop_i      (pop),
        .ready_o    (o_axi4s_a_tready),
        .nonempty_o (a_ne),
        .head_o     (a_head)
    );
    assign o_join_a = a_head[DATA_WIDTH-1:0];

    if (HAS_B != 0) begin : g_b
        logic [BW-1:0] b_head;
        ipsxe_fp_in_join_fifo #(.W(BW)) u_fifo_b (
            .clk        (i_aclk),
            .rst_n      (i_areset_n),
            .ce         (i_aclken),
            .valid_i    (i_axi4s_b_tvalid),
            .data_i     ({i_axi4s_b_tuser, i_axi4s_b_tdata}),
            .pop_i      (pop),
            .ready_o    (o_axi4s_b_tready),
            .nonempty_o (b_ne),
            .head_o     (b_head)
        );
        assign o_join_b = b_head[DATA_WIDTH-1:0];
        assign b_user   = b_head[BW-1:DATA_WIDTH];
    end else begin : g_no_b
        logic unused_b;
        assign o_axi4s_b_tready = 1'b0;
        assign b_ne             = 1'b1;
        assign o_join_b         = '0;
        assign b_user           = '0;
        assign unused_b = ^{i_axi4s_b_tvalid, i_axi4s_b_tdata, i_axi4s_b_tuser, b_user};
    end

    if (HAS_OP != 0) begin : g_op
        logic [OW-1:0] op_head;
        ipsxe_fp_in_join_fifo #(.W(OW)) u_fifo_op (
            .clk        (i_aclk),
            .rst_n      (i_areset_n),
            .ce         (i_aclken),
            .valid_i    (i_axi4s_op_tvalid),
            .data_i     ({i_axi4s_op_tuser, i_axi4s_op_tdata}),
            .pop_i      (pop),
            .ready_o    (o_axi4s_op_tready),
            .nonempty_o (op_ne),
            .head_o     (op_head)
        );
        assign o_join_op = op_head[OP_WIDTH-1:0];
        assign op_user   = op_head[OW-1:OP_WIDTH];
    end else begin : g_no_op
        logic unused_op;
        assign o_axi4s_op_tready = 1'b0;
        assign op_ne             = 1'b1;
        assign o_join_op         = '0;
        assign op_user           = '0;
        assign unused_op = ^{i_axi4s_op_tvalid, i_axi4s_op_tdata, i_axi4s_op_tuser, op_user};
    end

    // Absent channels contribute no bits; A always occupies the LSBs.
    if (HAS_B != 0 && HAS_OP != 0) begin : g_u_abo
        assign o_join_abcoperation_tuser = {op_user, b_user, a_head[AW-1:DATA_WIDTH]};
    end else if (HAS_B != 0) begin : g_u_ab
        assign o_join_abcoperation_tuser = {b_user, a_head[AW-1:DATA_WIDTH]};
    end else if (HAS_OP != 0) begin : g_u_ao
        assign o_join_abcoperation_tuser = {op_user, a_head[AW-1:DATA_WIDTH]};
    end else begin : g_u_a
        assign o_join_abcoperation_tuser = a_head[AW-1:DATA_WIDTH];
    end

endmodule

// File: doc/ipsxe_floating_point_in_join_v1_0.md
# ipsxe_floating_point_in_join_v1_0

Input-side channel joiner for the floating-point core. It accepts up to three independent AXI4-Stream slave channels: operand A, operand B and operation. Each channel is buffered in a 2-entry FIFO. When every enabled channel holds data, the block presents one joined beat to the arithmetic pipeline, with operand data plus the packed `abcoperation` tuser vector. The result-side tuser logic later delays that vector and re-emits it.

## Interface

Parameters:
- `HAS_B`, 1 — operand B channel enabled (0 leaves B ports unused; B tready driven 0).
- `HAS_OP`, 0 — operation channel enabled (0 leaves OP ports unused; OP tready driven 0).
- `DATA_WIDTH`, 32 — A/B tdata width.
- `OP_WIDTH`, 8 — operation tdata width.
- `A_TUSER_WIDTH`, 1 — A tuser width, ≥1.
- `B_TUSER_WIDTH`, 1 — B tuser width, ≥1.
- `OP_TUSER_WIDTH`, 1 — OP tuser width, ≥1.
- `TUSER_IN_ABCOPERATION_WIDTH`, derived — `A_TUSER_WIDTH + HAS_B*B_TUSER_WIDTH + HAS_OP*OP_TUSER_WIDTH`.

Ports:
- `i_aclk` in, 1 — clock.
- `i_areset_n` in, 1 — reset. Synchronous, active-low.
- `i_aclken` in, 1 — clock enable. All state holds while low.
- `i_axi4s_a_tvalid` / `o_axi4s_a_tready` in/out, 1 — A handshake.
- `i_axi4s_a_tdata` in, `DATA_WIDTH` — A data.
- `i_axi4s_a_tuser` in, `A_TUSER_WIDTH` — A tuser.
- `i_axi4s_b_tvalid` / `o_axi4s_b_tready` in/out, 1 — B handshake.
- `i_axi4s_b_tdata` in, `DATA_WIDTH` — B data.
- `i_axi4s_b_tuser` in, `B_TUSER_WIDTH` — B tuser.
- `i_axi4s_op_tvalid` / `o_axi4s_op_tready` in/out, 1 — OP handshake.
- `i_axi4s_op_tdata` in, `OP_WIDTH` — OP data.
- `i_axi4s_op_tuser` in, `OP_TUSER_WIDTH` — OP tuser.
- `o_join_valid` out, 1 — joined beat available.
- `i_join_ready` in, 1 — core accepts beat.
- `o_join_a` out, `DATA_WIDTH` — A head data.
- `o_join_b` out, `DATA_WIDTH` — B head data; 0 if `!HAS_B`.
- `o_join_op` out, `OP_WIDTH` — OP head data; 0 if `!HAS_OP`.
- `o_join_abcoperation_tuser` out, `TUSER_IN_ABCOPERATION_WIDTH` — `{op_tuser, b_tuser, a_tuser}` with A in the LSBs; absent fields are omitted.

## Operation

- **Per-channel FIFO:** 2 entries, with write pointer, read pointer and 2-bit count (0..2). Each entry stores `{tuser, tdata}`.
- **Push:** occurs when `tvalid && tready && i_aclken`.
- **Pop (all enabled channels simultaneously):** occurs when `o_join_valid && i_join_ready && i_aclken`.
- **Count update:** count_next = count + push − pop. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo 2.
- **tready:** registered, `tready <= (count_next < 2)`, updated only when `i_aclken`. A full channel therefore deasserts tready on the edge where it becomes full. A channel at count 2 with a pop re-asserts tready on that edge.
- **`o_join_valid`:** AND of (count ≠ 0) over enabled channels, decoded from registers. There is no combinational path from any tvalid or `i_join_ready` to any output.
- **`o_join_*`:** FIFO head entries. They are stable while `o_join_valid && !i_join_ready`.
- **Channel skew:** an early channel fills to 2 and then back-pressures. No beat is dropped, reordered or duplicated.
- **`i_aclken` low:** no push, no pop, all registers hold, and outputs hold their values.
- **Reset** (`!i_areset_n` at an edge, regardless of `i_aclken`):
  - counts and pointers go to 0;
  - all tready go to 0;
  - `o_join_valid` goes to 0;
  - stored data is not cleared but is not visible.
- **After reset:** tready rises at the first enabled edge with reset deasserted. Reset mid-operation discards all buffered beats.

## Timing

- **Latency:** a beat pushed at edge k (last channel to arrive) gives `o_join_valid` = 1 after edge k. That is one cycle from the completing handshake to output.
- **Throughput:** 1 joined beat per enabled cycle when all channels stream continuously and `i_join_ready` = 1. Counts stay at 1 and tready stays 1.
- **Stall:** with `i_join_ready` = 0 and continuous input, each channel accepts exactly 2 beats, then its tready is 0 from the following cycle.
- **Reset values:** all tready 0, `o_join_valid` 0.

## Test plan

- **Reset:** hold `i_areset_n` = 0 for 3 cycles with all tvalid = 1 → all tready = 0 and `o_join_valid` = 0. On the first edge after release, tready = 1.
- **Single beat** (`HAS_B`=1, `HAS_OP`=1): A = 0x3F800000/tuser 1, B = 0x40000000/tuser 0, OP = 0x05/tuser 1, all on one edge → next cycle `o_join_valid` = 1, `o_join_abcoperation_tuser` = 3'b101, and the data matches the inputs.
- **Skew:** present 3 A beats (0x1, 0x2, 0x3) with B idle → A accepts 2 beats, then a_tready = 0. Feed B 0x10, 0x20 → joined pairs (0x1,0x10), (0x2,0x20) in order. Beat 0x3 is accepted after the first pop.
- **Backpressure:** stream 10 beats with `i_join_ready` toggling 1/0 each cycle → all 10 beats output in order, none lost or duplicated, and count never exceeds 2.
- **Clock enable:** deassert `i_aclken` for 4 cycles while `o_join_valid` = 1 and `i_join_ready` = 1 → no pop and outputs stable. Resume → exactly one pop per enabled cycle.
- **Mid-operation reset:** both FIFOs full, then assert reset for 1 cycle → `o_join_valid` = 0. The next outputs come only from beats pushed after release.
